// File: rtl/cpu_sequencer_if.sv
// Byte-wide memory port between the sequencer (master) and the arbiter (slave).
// Signals: mem_req/mem_we/mem_addr/mem_wdata out of master, mem_ack/mem_rdata in.
interface cpu_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: PC, 1/2-byte fetch, operand access, execute strobe.
// Ports: clk, rst_n, run, mem (memory port), inst, data, dec_en, dec_need_mem,
// dec_store, dec_halt, dec_trap, operand_addr, store_data, branch_taken,
// branch_target, exec_stb, pc, halted, step. Option: SEQ_STEP_EN (single-step).
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] TRAP_VECTOR = 16'h0004
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  cpu_sequencer_if.master        mem,
  output logic [15:0]            inst,
  output logic [7:0]             data,
  output logic                   dec_en,
  input  logic                   dec_need_mem,
  input  logic                   dec_store,
  input  logic                   dec_halt,
  input  logic                   dec_trap,
  input  logic [15:0]            operand_addr,
  input  logic [7:0]             store_data,
  input  logic                   branch_taken,
  input  logic [15:0]            branch_target,
  output logic                   exec_stb,
  output logic [15:0]            pc,
  output logic                   halted,
  input  logic                   step
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH0  = 3'd1;
  localparam logic [2:0] S_FETCH1  = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_OPERAND = 3'd4;
  localparam logic [2:0] S_EXEC    = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        go;
  logic [2:0]  after_exec;

`ifdef SEQ_STEP_EN
  logic step_q;
  logic unused_run;

  assign unused_run = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  // one instruction per rising edge of step
  assign go         = step & ~step_q;
  assign after_exec = S_IDLE;
`else
  logic unused_step;

  assign unused_step = step;
  assign go          = run;
  assign after_exec  = S_FETCH0;
`endif

  logic st_f0;
  logic st_f1;
  logic st_dec;
  logic st_op;
  logic st_ex;
  logic st_halt;

  assign st_f0   = (state == S_FETCH0);
  assign st_f1   = (state == S_FETCH1);
  assign st_dec  = (state == S_DECODE);
  assign st_op   = (state == S_OPERAND);
  assign st_ex   = (state == S_EXEC);
  assign st_halt = (state == S_HALT);

  // an ack only counts while we are actually requesting
  logic ack;
  assign ack = mem.mem_req & mem.mem_ack;

  logic [15:0] pc_inc;
  logic [15:0] pc_seq;
  logic [15:0] pc_nx;

  assign pc_inc = pc + 16'd1;
  assign pc_seq = pc + (inst[15] ? 16'd2 : 16'd1);

  always_comb begin
    pc_nx = pc_seq;
    if (branch_taken)  pc_nx = branch_target;
    else if (dec_trap) pc_nx = TRAP_VECTOR;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (go) state_nx = S_FETCH0;
      S_FETCH0:  if (ack)
                   state_nx = mem.mem_rdata[7] ? S_FETCH1
                                               : S_DECODE;
      S_FETCH1:  if (ack) state_nx = S_DECODE;
      S_DECODE:  state_nx = dec_need_mem ? S_OPERAND : S_EXEC;
      S_OPERAND: if (ack) state_nx = S_EXEC;
      S_EXEC:    state_nx = dec_halt ? S_HALT : after_exec;
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      inst  <= 16'h0000;
      data  <= 8'h00;
    end else begin
      state <= state_nx;
      if (st_f0 && ack) inst <= {mem.mem_rdata, 8'h00};
      if (st_f1 && ack) inst[7:0] <= mem.mem_rdata;
      if (st_op && ack && !dec_store) data <= mem.mem_rdata;
      if (st_ex) pc <= pc_nx;
    end
  end

  // bus outputs decode straight from state so reset drops them at once
  assign mem.mem_req   = st_f0 | st_f1 | st_op;
  assign mem.mem_we    = st_op & dec_store;
  assign mem.mem_wdata = (st_op & dec_store) ? store_data : 8'h00;

  always_comb begin
    mem.mem_addr = 16'h0000;
    unique case (1'b1)
      st_f0:   mem.mem_addr = pc;
      st_f1:   mem.mem_addr = pc_inc;
      st_op:   mem.mem_addr = operand_addr;
      default: ;
    endcase
  end

  assign dec_en   = st_dec | st_op | st_ex;
  assign exec_stb = st_ex;
  assign halted   = st_halt;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction sequencer for the 16-bit accumulator CPU. Owns the program counter, fetches one- or two-byte instructions over the shared byte-wide memory port, presents the instruction word to the combinational decoder with its enable, fetches or writes the RAM operand byte when needed, and issues a single-cycle execute strobe to the datapath. Sits between the memory arbiter and the decoder/ALU.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- TRAP_VECTOR, 16'h0004, PC loaded on a trap instruction.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; leave IDLE and start fetching while high.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier, valid with mem_req.
- mem_addr  out  16  byte address, valid with mem_req.
- mem_wdata  out  8  write byte, valid with mem_req & mem_we.
- mem_ack  in  1  access complete this cycle; mem_rdata valid when reading.
- mem_rdata  in  8  read byte.
- inst  out  16  instruction register to decoder.
- data  out  8  operand byte register to decoder.
- dec_en  out  1  decoder enable.
- dec_need_mem  in  1  decoder source_ram | source_indirect.
- dec_store  in  1  decoder inst_store.
- dec_halt  in  1  decoder inst_halt.
- dec_trap  in  1  decoder inst_trap.
- operand_addr  in  16  effective operand address from datapath.
- store_data  in  8  byte to write for a store.
- branch_taken  in  1  datapath: load PC from branch_target at execute.
- branch_target  in  16  next PC when branch_taken.
- exec_stb  out  1  one-cycle execute strobe.
- pc  out  16  current program counter.
- halted  out  1  high in HALT.
- step  in  1  single-step request (only with SEQ_STEP_EN).

## Operation

- States: IDLE, FETCH0, FETCH1, DECODE, OPERAND, EXEC, HALT.
- Reset (async): state IDLE, pc=RESET_PC, inst=0, data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dec_en=0, exec_stb=0, halted=0. An access in flight is abandoned; memory sees mem_req fall immediately.
- IDLE: run=1 -> FETCH0.
- FETCH0: mem_req=1, mem_addr=pc. On mem_ack: inst[15:8]=mem_rdata, inst[7:0]=0; rdata[7]=1 -> FETCH1, else -> DECODE.
- FETCH1: mem_addr=pc+1 (mod 2^16). On mem_ack: inst[7:0]=mem_rdata -> DECODE.
- DECODE: dec_en=1, no memory request. dec_need_mem=1 -> OPERAND, else -> EXEC.
- OPERAND: dec_en=1, mem_req=1, mem_addr=operand_addr, mem_we=dec_store, mem_wdata=store_data. On mem_ack: if read, data=mem_rdata -> EXEC.
- EXEC: dec_en=1, exec_stb=1 for exactly one cycle. Next pc: branch_taken -> branch_target; else dec_trap -> TRAP_VECTOR; else pc+len, len=1 or 2 per inst[15], wrapping mod 2^16. branch_taken has priority over trap. dec_halt -> HALT (pc still advances past the halt); else -> FETCH0, ignoring run.
- HALT: halted=1, no requests; exit only by reset.
- run falling only takes effect in IDLE; a running sequencer never returns to IDLE except by reset or single-step.

## Timing

- Handshake: mem_req and mem_addr/mem_we/mem_wdata stable from assertion until the mem_ack cycle inclusive. mem_ack may arrive in the first request cycle (zero-wait). mem_req deasserts the cycle after ack unless the next state also requests; back-to-back FETCH0->FETCH1 keeps mem_req high with a new address. mem_ack while mem_req=0 is ignored.
- Zero-wait cycles per instruction: 1-byte = 3 (FETCH0, DECODE, EXEC); 2-byte = 4; 2-byte with operand = 5. Each wait state adds one cycle.
- inst/data change only on ack edges; stable throughout DECODE/OPERAND/EXEC.
- pc changes only on the EXEC edge.

## Configuration

- SEQ_STEP_EN defined: after EXEC (non-halt) enter IDLE instead of FETCH0; leave IDLE only on a rising edge of step (registered), run ignored. One instruction per step pulse.
- Not defined: step port present but ignored; behaviour as above.

## Test plan

- Reset, run=1, memory {0x00@0} zero-wait -> mem_addr 0, exec_stb in cycle 3, pc=0x0001.
- Two-byte 0x8812 at 0x0010 -> fetches 0x0010, 0x0011; inst=0x8812; pc=0x0012 after 4 cycles.
- Operand read with dec_need_mem=1, operand_addr=0x0200, rdata 0x5A, ack after 2 waits -> data=0x5A, exec_stb 7 cycles after fetch start.
- Two-byte instr at 0xFFFF -> second fetch at 0x0000, pc wraps to 0x0001; branch_taken with target 0x1234 plus dec_trap -> pc=0x1234.
- Halt (0x01) -> halted=1, mem_req stays 0 for 100 cycles; rst_n low mid-FETCH1 wait -> mem_req 0 immediately, pc=RESET_PC.
- SEQ_STEP_EN: three step pulses -> exactly three exec_stb pulses, sequencer in IDLE between.
